// File: rtl/tp2_dlf_gearshift.sv
// ---------------------------------------------------------------------------
// tp2_dlf_gearshift
//
// Bang-bang digital loop filter for a DPLL with automatic gain gear-shifting.
// A proportional/integral path is driven by the 1-bit phase-detector output,
// followed by a sum register, a cascade of NIIR single-pole IIR stages, and a
// rounding or first-order DSM quantiser that produces the oscillator tuning
// word. A small FSM (ACQ -> SETTLE -> TRK) watches the PDE toggle pattern to
// pick acquisition or tracking gains and raise LOCKED.
//
// Parameters
//   WI, WF      integer / fraction bits of the filter word (W = WI+WF)
//   NIIR        number of IIR stages (1..4)
//   CW          width of the lock / loss counters
//   SETTLE_CYC  enabled cycles spent in SETTLE before TRK
//
// Ports
//   CKVD        loop clock
//   NRST        asynchronous active-low reset
//   PDE         phase error: 1 = late (+), 0 = early (-)
//   DLFEN       update enable for prop/inte, counters and FSM
//   KPS_ACQ/KIS_ACQ/KPS_TRK/KIS_TRK  signed log2 gain shifts (6 bits)
//   KIIRS       per-stage signed IIR shift, stage k at [6k+5:6k]
//   IIREN       per-stage IIR enable (disabled stage passes x through)
//   DSMEN       fractional DSM enable
//   LOCK_TH     toggle count that declares lock (0 = never)
//   LOSS_TH     same-sign run that declares loss (0 = never)
//   GEAR_HOLD   forces and holds gear ACQ
//   DCTRL       oscillator tuning word
//   LOCKED      1 only while in TRK
//   GEAR        FSM state: 0 = ACQ, 1 = SETTLE, 2 = TRK
//
// Enable semantics: DLFEN qualifies a PDE sample. A PDE value is "accepted"
// on a CKVD edge only when DLFEN=1; with DLFEN=0 the front end (prop, inte,
// counters, FSM) holds, while the sum/IIR/quantiser pipeline keeps clocking.
// ---------------------------------------------------------------------------
module tp2_dlf_gearshift #(
    parameter int WI         = 7,
    parameter int WF         = 26,
    parameter int NIIR       = 4,
    parameter int CW         = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic                CKVD,
    input  logic                NRST,
    input  logic                PDE,
    input  logic                DLFEN,
    input  logic [5:0]          KPS_ACQ,
    input  logic [5:0]          KIS_ACQ,
    input  logic [5:0]          KPS_TRK,
    input  logic [5:0]          KIS_TRK,
    input  logic [6*NIIR-1:0]   KIIRS,
    input  logic [NIIR-1:0]     IIREN,
    input  logic                DSMEN,
    input  logic [CW-1:0]       LOCK_TH,
    input  logic [CW-1:0]       LOSS_TH,
    input  logic                GEAR_HOLD,
    output logic [WI-1:0]       DCTRL,
    output logic                LOCKED,
    output logic [1:0]          GEAR
);

    localparam int W  = WI + WF;
    localparam int SW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

    localparam logic [W-1:0]  W_ONE  = W'(1);
    localparam logic [W-1:0]  W_MID  = W_ONE << (W - 1);
    localparam logic [W-1:0]  W_MAX  = '1;
    localparam logic [WI-1:0] D_MID  = WI'(1) << (WI - 1);
    localparam logic [WI-1:0] D_MAX  = '1;
    localparam logic [CW-1:0] C_MAX  = '1;

    typedef enum logic [1:0] {
        G_ACQ    = 2'd0,
        G_SETTLE = 2'd1,
        G_TRK    = 2'd2
    } gear_t;

    // K = 2^(WF+s) when the exponent lands inside the word, else 0.
    function automatic logic [W-1:0] shift_gain(input logic [5:0] s);
        int e;
        e = WF + int'($signed(s));
        if (e >= 0 && e < W)
            return W_ONE << e;
        else
            return '0;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    gear_t            state_q, state_d;
    logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
    logic [CW-1:0]    loss_cnt_q, loss_cnt_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic             prev_pde_q;

    logic [W:0]       prop_q, prop_d;       // two's complement, W+1 bits
    logic [W-1:0]     inte_q, inte_d;       // unsigned, saturating
    logic [W-1:0]     sum_q, sum_d;
    logic [WF-1:0]    acc_q, acc_d;         // DSM accumulator
    logic [WI-1:0]    dctrl_q, dctrl_d;

    logic [W-1:0]     iir_x [NIIR];
    logic [W-1:0]     iir_y [NIIR];

    // ------------------------------------------------------------------
    // Gain selection: ACQ gains only in ACQ; SETTLE already uses TRK gains
    // so the loop quiets down before LOCKED is raised.
    // ------------------------------------------------------------------
    logic [W-1:0] kp, ki;

    always_comb begin
        if (state_q == G_ACQ) begin
            kp = shift_gain(KPS_ACQ);
            ki = shift_gain(KIS_ACQ);
        end else begin
            kp = shift_gain(KPS_TRK);
            ki = shift_gain(KIS_TRK);
        end
    end

    // ------------------------------------------------------------------
    // Proportional / integral front end
    // ------------------------------------------------------------------
    logic [W:0] inte_add, inte_sub;

    always_comb begin
        prop_d   = PDE ? {1'b0, kp} : -{1'b0, kp};
        inte_add = {1'b0, inte_q} + {1'b0, ki};
        inte_sub = {1'b0, inte_q} - {1'b0, ki};
        // Carry out clamps high, borrow clamps at zero: the integrator
        // never wraps.
        if (PDE)
            inte_d = inte_add[W] ? W_MAX : inte_add[W-1:0];
        else
            inte_d = inte_sub[W] ? '0 : inte_sub[W-1:0];
    end

    // ------------------------------------------------------------------
    // Sum register: inte (unsigned) + prop (signed) in W+2 bits. Bit W+1
    // is only set for a negative result, bit W only for overflow.
    // ------------------------------------------------------------------
    logic [W+1:0] sum_ext;

    always_comb begin
        sum_ext = {2'b00, inte_q} + {prop_q[W], prop_q};
        if (sum_ext[W+1])
            sum_d = '0;
        else if (sum_ext[W])
            sum_d = W_MAX;
        else
            sum_d = sum_ext[W-1:0];
    end

    // ------------------------------------------------------------------
    // IIR cascade. Every stage is registered whether enabled or not, so
    // the PDE-to-DCTRL latency is fixed at NIIR+2. A disabled stage
    // tracks its input, which makes a later enable start with x == y.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NIIR; k++) begin : g_iir
        logic [W-1:0] y_q, y_d;
        logic [5:0]   sh, nsh;
        logic [W:0]   diff;
        logic [W-1:0] step;

        if (k == 0) begin : g_src_sum
            assign iir_x[k] = sum_q;
        end else begin : g_src_prev
            assign iir_x[k] = iir_y[k-1];
        end

        always_comb begin
            sh   = KIIRS[6*k +: 6];
            nsh  = -sh;
            diff = {1'b0, iir_x[k]} - {1'b0, y_q};
            // Negative shift code means a left shift by its magnitude.
            if (sh[5])
                step = W'($signed(diff) <<< nsh);
            else
                step = W'($signed(diff) >>> sh);
            y_d = IIREN[k] ? (y_q + step) : iir_x[k];
        end

        always_ff @(posedge CKVD or negedge NRST) begin
            if (!NRST)
                y_q <= W_MID;
            else
                y_q <= y_d;
        end

        assign iir_y[k] = y_q;
    end

    // ------------------------------------------------------------------
    // Quantiser: round half-up on the fraction MSB, or add the carry of
    // a first-order fractional accumulator when DSMEN=1.
    // ------------------------------------------------------------------
    logic [WI-1:0] int_f;
    logic [WF-1:0] frac_f;
    logic [WF:0]   dsm_sum;
    logic          inc;
    logic [WI:0]   dc_ext;

    always_comb begin
        int_f   = iir_y[NIIR-1][W-1:WF];
        frac_f  = iir_y[NIIR-1][WF-1:0];
        dsm_sum = {1'b0, acc_q} + {1'b0, frac_f};
        inc     = DSMEN ? dsm_sum[WF] : frac_f[WF-1];
        acc_d   = DSMEN ? dsm_sum[WF-1:0] : acc_q;
        dc_ext  = {1'b0, int_f} + {{WI{1'b0}}, inc};
        dctrl_d = dc_ext[WI] ? D_MAX : dc_ext[WI-1:0];
    end

    // ------------------------------------------------------------------
    // Gear FSM, next-state / counters
    // ------------------------------------------------------------------
    logic          toggle;
    logic [CW-1:0] lock_inc, loss_inc;

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        settle_cnt_d = settle_cnt_q;
        toggle       = PDE ^ prev_pde_q;
        lock_inc     = (lock_cnt_q == C_MAX) ? lock_cnt_q : lock_cnt_q + CW'(1);
        loss_inc     = (loss_cnt_q == C_MAX) ? loss_cnt_q : loss_cnt_q + CW'(1);

        // GEAR_HOLD acts on every edge, even with DLFEN=0, so software
        // can park the loop in ACQ without also having to enable it.
        if (GEAR_HOLD) begin
            state_d      = G_ACQ;
            lock_cnt_d   = '0;
            loss_cnt_d   = '0;
            settle_cnt_d = '0;
        end else if (DLFEN) begin
            case (state_q)
                G_ACQ: begin
                    lock_cnt_d   = toggle ? lock_inc : '0;
                    loss_cnt_d   = '0;
                    settle_cnt_d = '0;
                    if (LOCK_TH != '0 && lock_cnt_d >= LOCK_TH) begin
                        state_d    = G_SETTLE;
                        lock_cnt_d = '0;
                    end
                end
                G_SETTLE: begin
                    lock_cnt_d = '0;
                    loss_cnt_d = '0;
                    if (int'(settle_cnt_q) + 1 >= SETTLE_CYC) begin
                        state_d      = G_TRK;
                        settle_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SW'(1);
                    end
                end
                G_TRK: begin
                    lock_cnt_d   = '0;
                    settle_cnt_d = '0;
                    loss_cnt_d   = toggle ? '0 : loss_inc;
                    if (LOSS_TH != '0 && loss_cnt_d >= LOSS_TH) begin
                        state_d    = G_ACQ;
                        loss_cnt_d = '0;
                    end
                end
                default: begin
                    state_d      = G_ACQ;
                    lock_cnt_d   = '0;
                    loss_cnt_d   = '0;
                    settle_cnt_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CKVD or negedge NRST) begin
        if (!NRST) begin
            state_q      <= G_ACQ;
            lock_cnt_q   <= '0;
            loss_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    // Integrator is untouched by gear changes; only the gain applied to
    // the next update differs.
    always_ff @(posedge CKVD or negedge NRST) begin
        if (!NRST) begin
            prop_q     <= '0;
            inte_q     <= W_MID;
            prev_pde_q <= 1'b0;
        end else if (DLFEN) begin
            prop_q     <= prop_d;
            inte_q     <= inte_d;
            prev_pde_q <= PDE;
        end
    end

    always_ff @(posedge CKVD or negedge NRST) begin
        if (!NRST) begin
            sum_q   <= W_MID;
            acc_q   <= '0;
            dctrl_q <= D_MID;
        end else begin
            sum_q   <= sum_d;
            acc_q   <= acc_d;
            dctrl_q <= dctrl_d;
        end
    end

    assign DCTRL  = dctrl_q;
    assign GEAR   = state_q;
    assign LOCKED = (state_q == G_TRK);

endmodule

// File: tb/tb_tp2_dlf_gearshift.sv
// ---------------------------------------------------------------------------
// tb_tp2_dlf_gearshift
//
// Directed bench for tp2_dlf_gearshift (NIIR=2, other parameters default).
// Expected DCTRL sequences are hand-computed and pushed into exp_q, then
// popped one per clock; FSM/lock expectations are compared inline.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// at the same point, well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_tp2_dlf_gearshift;

    localparam int WI         = 7;
    localparam int WF         = 26;
    localparam int NIIR       = 2;
    localparam int CW         = 8;
    localparam int SETTLE_CYC = 16;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic              ckvd = 1'b0;
    logic              nrst = 1'b0;
    logic              pde;
    logic              dlfen;
    logic [5:0]        kps_acq, kis_acq, kps_trk, kis_trk;
    logic [6*NIIR-1:0] kiirs;
    logic [NIIR-1:0]   iiren;
    logic              dsmen;
    logic [CW-1:0]     lock_th, loss_th;
    logic              gear_hold;
    logic [WI-1:0]     dctrl;
    logic              locked;
    logic [1:0]        gear;

    always #5 ckvd = ~ckvd;

    tp2_dlf_gearshift #(
        .WI(WI), .WF(WF), .NIIR(NIIR), .CW(CW), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .CKVD(ckvd), .NRST(nrst), .PDE(pde), .DLFEN(dlfen),
        .KPS_ACQ(kps_acq), .KIS_ACQ(kis_acq), .KPS_TRK(kps_trk), .KIS_TRK(kis_trk),
        .KIIRS(kiirs), .IIREN(iiren), .DSMEN(dsmen),
        .LOCK_TH(lock_th), .LOSS_TH(loss_th), .GEAR_HOLD(gear_hold),
        .DCTRL(dctrl), .LOCKED(locked), .GEAR(gear)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [WI-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge ckvd);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    // One clock per queued value, DCTRL compared against the head.
    task automatic run_exp(input string tag);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            step();
            check($sformatf("%s[%0d]", tag, cyc), dctrl, exp_q.pop_front());
            cyc++;
        end
    endtask

    task automatic push_exp(input int v, input int n);
        repeat (n) exp_q.push_back(WI'(v));
    endtask

    task automatic toggle_n(input int n);
        repeat (n) begin
            pde = ~pde;
            step();
        end
    endtask

    // Clear the lock counter with a same-sign sample, then toggle through
    // 8 lock toggles and 16 SETTLE cycles (needs LOCK_TH=8).
    task automatic drive_to_trk(input string tag);
        step_n(2);
        toggle_n(8 + SETTLE_CYC);
        check(tag, gear, 2);
    endtask

    // Assert reset mid-cycle; outputs must go to reset values before the
    // next edge and stay there while NRST is low.
    task automatic pulse_reset(input string tag);
        #3;
        nrst = 1'b0;
        #1;
        check({tag, "_dctrl"}, dctrl, 64);
        check({tag, "_gear"}, gear, 0);
        check({tag, "_locked"}, locked, 0);
        step_n(2);
        check({tag, "_dctrl_held"}, dctrl, 64);
        #2;
        nrst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        pde       = 1'b0;
        dlfen     = 1'b0;
        kps_acq   = 6'd0;
        kis_acq   = -6'd27;        // WF-27 < 0 -> KI = 0
        kps_trk   = 6'd1;          // KP = 2.0 in TRK, visible on DCTRL
        kis_trk   = -6'd27;
        kiirs     = '0;
        iiren     = '0;
        dsmen     = 1'b0;
        lock_th   = '0;
        loss_th   = '0;
        gear_hold = 1'b0;

        // Power-on reset values
        #12;
        check("por_dctrl", dctrl, 64);
        check("por_gear", gear, 0);
        check("por_locked", locked, 0);
        @(posedge ckvd);
        #3;
        nrst = 1'b1;

        // Latency: DLFEN=0 keeps prop at 0, then PDE=1 is sampled at edge n
        push_exp(64, 3);
        run_exp("hold_dlfen0");
        dlfen = 1'b1;
        pde   = 1'b1;
        push_exp(64, 4);
        push_exp(65, 2);
        run_exp("latency_up");
        pde = 1'b0;
        push_exp(65, 4);
        push_exp(63, 1);
        run_exp("latency_dn");

        // LOCK_TH=0 never declares lock
        toggle_n(20);
        check("lock_th0_gear", gear, 0);
        check("lock_th0_locked", locked, 0);

        // Lock: 8 toggles -> SETTLE, 16 cycles later TRK
        lock_th = 8'd8;
        loss_th = 8'd16;
        step_n(2);
        for (int i = 1; i <= 8; i++) begin
            pde = ~pde;
            step();
            check($sformatf("lock_gear[%0d]", i), gear, (i == 8) ? 1 : 0);
        end
        for (int j = 1; j <= SETTLE_CYC; j++) begin
            pde = ~pde;
            step();
            check($sformatf("settle_gear[%0d]", j), gear, (j == SETTLE_CYC) ? 2 : 1);
            check($sformatf("settle_locked[%0d]", j), locked, (j == SETTLE_CYC) ? 1 : 0);
        end

        // Loss: PDE held 1 in TRK; the first edge is still a toggle
        pde = 1'b1;
        step();
        check("loss_first_gear", gear, 2);
        for (int j = 1; j <= 16; j++) begin
            step();
            check($sformatf("loss_gear[%0d]", j), gear, (j == 16) ? 0 : 2);
            check($sformatf("loss_locked[%0d]", j), locked, (j == 16) ? 0 : 1);
            if (j == 15) check("trk_gain_dctrl", dctrl, 66);
        end
        step_n(5);
        check("acq_gain_dctrl", dctrl, 65);

        // GEAR_HOLD pulse in TRK, then hold priority over lock
        drive_to_trk("to_trk_a");
        gear_hold = 1'b1;
        pde = ~pde;
        step();
        check("hold_gear", gear, 0);
        check("hold_locked", locked, 0);
        toggle_n(12);
        check("hold_prio_gear", gear, 0);
        gear_hold = 1'b0;
        toggle_n(8);
        check("relock_gear", gear, 1);
        toggle_n(SETTLE_CYC);
        check("relock_trk", gear, 2);

        // Reset mid-run in TRK with DLFEN=1; then saturation from reset
        kis_acq = 6'd5;            // KI = 2^31
        kps_acq = 6'd0;
        lock_th = '0;
        pde     = 1'b1;
        pulse_reset("rst_trk");
        push_exp(64, 4);
        push_exp(97, 1);
        push_exp(127, 7);
        run_exp("sat_hi");
        pde = 1'b0;
        push_exp(127, 4);
        push_exp(95, 1);
        push_exp(63, 1);
        push_exp(31, 1);
        push_exp(0, 3);
        run_exp("sat_lo");

        // Bumpless IIR enable at steady state, then filtered step
        kis_acq = -6'd27;
        kiirs   = 12'h001;         // stage 0 shift 1, stage 1 shift 0
        pde     = 1'b1;
        pulse_reset("rst_b");
        step_n(8);
        check("steady_dctrl", dctrl, 65);
        iiren = 2'b01;
        push_exp(65, 8);
        run_exp("bumpless");
        pde = 1'b0;
        push_exp(65, 4);
        push_exp(64, 2);
        push_exp(63, 2);
        run_exp("iir_step");

        // Rounding vs DSM with a 0.5 fraction
        iiren   = 2'b00;
        kps_acq = -6'd1;           // KP = 0.5
        pde     = 1'b1;
        step_n(8);
        check("round_half", dctrl, 65);
        dsmen = 1'b1;
        exp_q.push_back(7'd64);
        exp_q.push_back(7'd65);
        exp_q.push_back(7'd64);
        run_exp("dsm_on");
        dsmen = 1'b0;
        push_exp(65, 2);
        run_exp("dsm_off");
        dsmen = 1'b1;
        exp_q.push_back(7'd65);
        exp_q.push_back(7'd64);
        run_exp("dsm_resume");

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
